// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues an I-cache read, waits out variable latency and
// strobes the fetched word into the instruction register. Owns flush and fetch timeout.
module fetch_sequencer #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned MAX_WAIT   = 255,
    parameter logic [3:0]  OPCODE_NOP = 4'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic              i_ready,
    input  logic [WORD_W-1:0] i_data,
    output logic              i_req,
    output logic [ADDR_W-1:0] i_addr,
    output logic              ir_write,
    output logic [WORD_W-1:0] ir_data,
    output logic              fetch_done,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       stall_cycles
);

    // state | meaning
    // IDLE  | waiting for fetch_start; address and IR contents held
    // REQ   | read request outstanding, counting wait cycles toward timeout
    // DONE  | fetched word valid on ir_data; IRWrite strobe unless flushed

    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [WORD_W-1:0] IR_RESET = {OPCODE_NOP, {(WORD_W-4){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [15:0]       stall_q, stall_d;
    logic              timeout_q, timeout_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            ir_q      <= IR_RESET;
            wait_q    <= '0;
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ir_d      = ir_q;
        wait_d    = wait_q;
        stall_d   = stall_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_start && !flush) begin
                    addr_d  = pc;
                    wait_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Flush wins over a same-cycle i_ready so a redirected fetch never loads IR.
                if (flush) begin
                    state_d = S_IDLE;
                end else if (i_ready) begin
                    ir_d    = i_data;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                    if (stall_q != 16'hFFFF) begin
                        stall_d = stall_q + 16'd1;
                    end
                    if (wait_q == WAIT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes decode the state directly so an async reset drops them without a clock edge.
    assign i_req        = (state_q == S_REQ);
    assign busy         = (state_q != S_IDLE);
    assign ir_write     = (state_q == S_DONE) && !flush;
    assign fetch_done   = ir_write;
    assign i_addr       = addr_q;
    assign ir_data      = ir_q;
    assign timeout_err  = timeout_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a default-timeout instance plus a MAX_WAIT=4
// instance on the same stimulus for the timeout scenario.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic [15:0] pc;
    logic        flush;
    logic        i_ready;
    logic [15:0] i_data;

    logic        i_req, ir_write, fetch_done, busy, timeout_err;
    logic [15:0] i_addr, ir_data, stall_cycles;
    logic        i_req_t, ir_write_t, fetch_done_t, busy_t, timeout_err_t;
    logic [15:0] i_addr_t, ir_data_t, stall_cycles_t;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    always #5 clk = ~clk;

    fetch_sequencer u_dut (
        .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc(pc), .flush(flush),
        .i_ready(i_ready), .i_data(i_data), .i_req(i_req), .i_addr(i_addr),
        .ir_write(ir_write), .ir_data(ir_data), .fetch_done(fetch_done), .busy(busy),
        .timeout_err(timeout_err), .stall_cycles(stall_cycles)
    );

    fetch_sequencer #(.MAX_WAIT(4)) u_dut_to (
        .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc(pc), .flush(flush),
        .i_ready(i_ready), .i_data(i_data), .i_req(i_req_t), .i_addr(i_addr_t),
        .ir_write(ir_write_t), .ir_data(ir_data_t), .fetch_done(fetch_done_t), .busy(busy_t),
        .timeout_err(timeout_err_t), .stall_cycles(stall_cycles_t)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        fetch_start = 1'b0;
        flush       = 1'b0;
        i_ready     = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; fetch_start = 1'b0; pc = '0; flush = 1'b0; i_ready = 1'b0; i_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ir_data", ir_data, 16'h0000);
        check("rst_ir_write", ir_write, 1'b0);
        check("rst_fetch_done", fetch_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_i_req", i_req, 1'b0);
        check("rst_i_addr", i_addr, 16'h0000);
        check("rst_timeout", timeout_err, 1'b0);
        check("rst_stall", stall_cycles, 16'h0000);

        // reset while in REQ
        @(negedge clk); fetch_start = 1'b1; pc = 16'h1234;
        @(negedge clk); fetch_start = 1'b0; #1;
        check("t1_req_before_rst", i_req, 1'b1);
        #1 reset = 1'b1; #1;
        check("t1_req_async_drop", i_req, 1'b0);
        check("t1_busy_async_drop", busy, 1'b0);
        @(negedge clk); reset = 1'b0; i_ready = 1'b1; i_data = 16'hBEEF;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            if (ir_write) cnt++;
        end
        check("t1_no_irwrite_after_rst", cnt, 0);
        check("t1_ir_data_kept", ir_data, 16'h0000);
        i_ready = 1'b0;

        // single-cycle memory
        @(negedge clk); fetch_start = 1'b1; pc = 16'h0040;
        @(negedge clk); fetch_start = 1'b0; i_ready = 1'b1; i_data = 16'hA123; #1;
        check("t2_i_req", i_req, 1'b1);
        check("t2_i_addr", i_addr, 16'h0040);
        check("t2_no_early_write", ir_write, 1'b0);
        @(negedge clk); i_ready = 1'b0; #1;
        check("t2_ir_write", ir_write, 1'b1);
        check("t2_fetch_done", fetch_done, 1'b1);
        check("t2_ir_data", ir_data, 16'hA123);
        @(negedge clk); #1;
        check("t2_write_pulse_end", ir_write, 1'b0);
        check("t2_idle", busy, 1'b0);

        // five wait cycles before i_ready
        @(negedge clk); fetch_start = 1'b1; pc = 16'h0080;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); fetch_start = 1'b0; i_ready = (k == 5); i_data = 16'h5A5A; #1;
            if (i_req) cnt++;
        end
        check("t3_req_cycles", cnt, 6);
        @(negedge clk); i_ready = 1'b0; #1;
        check("t3_ir_write", ir_write, 1'b1);
        check("t3_ir_data", ir_data, 16'h5A5A);
        check("t3_stall", stall_cycles, 16'd5);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            if (ir_write) cnt++;
        end
        check("t3_single_write", cnt, 0);

        // flush in REQ beats same-cycle i_ready
        @(negedge clk); fetch_start = 1'b1; pc = 16'h00C0;
        @(negedge clk); fetch_start = 1'b0; flush = 1'b1; i_ready = 1'b1; i_data = 16'hDEAD; #1;
        check("t4a_i_req", i_req, 1'b1);
        @(negedge clk); flush = 1'b0; i_ready = 1'b0; #1;
        check("t4a_idle", busy, 1'b0);
        check("t4a_no_write", ir_write, 1'b0);
        check("t4a_ir_data_kept", ir_data, 16'h5A5A);

        // flush during DONE
        @(negedge clk); fetch_start = 1'b1; pc = 16'h00E0;
        @(negedge clk); fetch_start = 1'b0; i_ready = 1'b1; i_data = 16'hCAFE;
        @(negedge clk); i_ready = 1'b0; flush = 1'b1; #1;
        check("t4b_busy_done", busy, 1'b1);
        check("t4b_write_suppressed", ir_write, 1'b0);
        check("t4b_done_suppressed", fetch_done, 1'b0);
        check("t4b_ir_data", ir_data, 16'hCAFE);
        @(negedge clk); flush = 1'b0; #1;
        check("t4b_idle", busy, 1'b0);
        check("t4b_no_timeout", timeout_err, 1'b0);

        // timeout on the MAX_WAIT=4 instance
        do_reset();
        @(negedge clk); fetch_start = 1'b1; pc = 16'h0100;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); fetch_start = 1'b0; #1;
            if (i_req_t) cnt++;
            if (ir_write_t) cnt += 100;
        end
        check("t5_req_cycles", cnt, 4);
        check("t5_timeout", timeout_err_t, 1'b1);
        check("t5_idle", busy_t, 1'b0);
        check("t5_stall", stall_cycles_t, 16'd4);
        check("t5_ir_data_kept", ir_data_t, 16'h0000);
        @(negedge clk); fetch_start = 1'b1; pc = 16'h0200;
        @(negedge clk); fetch_start = 1'b0; i_ready = 1'b1; i_data = 16'h1357; #1;
        check("t5_addr2", i_addr_t, 16'h0200);
        @(negedge clk); i_ready = 1'b0; #1;
        check("t5_write2", ir_write_t, 1'b1);
        check("t5_done2", fetch_done_t, 1'b1);
        check("t5_data2", ir_data_t, 16'h1357);
        check("t5_timeout_sticky", timeout_err_t, 1'b1);

        // back-to-back with fetch_start held
        do_reset();
        @(negedge clk); fetch_start = 1'b1; i_ready = 1'b1; pc = 16'h0300;
        cnt = 0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            i_data = 16'h7000 + 16'(k);
            if (k % 3 == 1) pc = pc + 16'h0100;
            #1;
            check($sformatf("t6_write_k%0d", k), ir_write, (k % 3 == 2));
            if (ir_write) cnt++;
            if (k % 3 == 1) check($sformatf("t6_addr_k%0d", k), i_addr, 16'h0300 + 16'h0100 * 16'(k / 3));
            if (k % 3 == 2) check($sformatf("t6_data_k%0d", k), ir_data, 16'h7000 + 16'(k - 1));
        end
        check("t6_write_count", cnt, 3);
        fetch_start = 1'b0; i_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
